// File: rtl/fifo_pkg.sv
// Shared constants and types for the stream FIFO and its storage.
package fifo_pkg;

  // OVERWRITE parameter values.
  localparam int unsigned MODE_REJECT      = 0;
  localparam int unsigned MODE_DROP_OLDEST = 1;

  // Default value returned by a read of an empty FIFO.
  // This constant is wide so that any practical WIDTH can slice it.
  localparam logic [1023:0] EMPTY_VALUE_DEFAULT = '1;

  // Selects which registered source currently drives data_out.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_MEM   = 2'd1,
    SRC_EMPTY = 2'd2
  } dout_src_e;

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage with one synchronous write port and one synchronous read port.
module fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read returns the pre-write contents when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_fifo.sv
// Streaming FIFO with one-cycle read latency, optional overwrite-oldest mode,
// registered status flags and a saturating overflow counter.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      OVERWRITE   = MODE_DROP_OLDEST,
  parameter int unsigned      AF_LEVEL    = DEPTH - 2,
  parameter int unsigned      AE_LEVEL    = 2,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = EMPTY_VALUE_DEFAULT[WIDTH-1:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic                   read,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  output logic [15:0]            drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          data_valid_q, data_valid_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic [15:0]   drop_q, drop_d;
  dout_src_e     src_q, src_d;

  logic          is_full, is_empty, rd_ok, wr_en, rd_adv;
  logic [WIDTH-1:0] mem_rd_data;

  // Next-state computation for pointers, occupancy and event pulses.
  always_comb begin
    is_full      = (count_q == DEPTH_C);
    is_empty     = (count_q == '0);
    rd_ok        = read && !is_empty;
    overflow_d   = write && is_full && !read;
    underflow_d  = read && is_empty;
    // A write while full without a read is only accepted in drop-oldest mode.
    wr_en        = write && (!is_full || rd_ok || (OVERWRITE == MODE_DROP_OLDEST));
    rd_adv       = rd_ok || (overflow_d && (OVERWRITE == MODE_DROP_OLDEST));
    data_valid_d = rd_ok;

    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (rd_adv) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
    end

    count_d = count_q;
    if (rd_ok && !wr_en) begin
      count_d = count_q - CW'(1);
    end else if (wr_en && !rd_ok && !is_full) begin
      count_d = count_q + CW'(1);
    end

    drop_d = drop_q;
    if (overflow_d && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    src_d = src_q;
    if (underflow_d) begin
      src_d = SRC_EMPTY;
    end else if (rd_ok) begin
      src_d = SRC_MEM;
    end
  end

  // State, flag and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      af_q         <= 1'b0;
      ae_q         <= 1'b1;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      drop_q       <= '0;
      src_q        <= SRC_ZERO;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= (count_d == DEPTH_C);
      empty_q      <= (count_d == '0);
      af_q         <= (count_d >= AF_C);
      ae_q         <= (count_d <= AE_C);
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      drop_q       <= drop_d;
      src_q        <= src_d;
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en && !reset),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_ok && !reset),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // data_out selects between registered sources: the memory read register
  // holds the last popped word, so only the select needs a flop here.
  always_comb begin
    data_out = '0;
    case (src_q)
      SRC_MEM:   data_out = mem_rd_data;
      SRC_EMPTY: data_out = EMPTY_VALUE;
      default:   data_out = '0;
    endcase
  end

  assign data_valid   = data_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign drop_count   = drop_q;

endmodule
